// File: rtl/cpu_mem_responder.sv
// CPU bus responder: internal RAM, PPU register window, PRG ROM pass-through and OAM DMA engine.
// All CPU-visible results are registered; a DMA stalls the CPU until the whole 256-byte page is copied.
module cpu_mem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write_en,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_data,
    output logic [2:0]  ppu_reg_sel,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_wr,
    output logic        ppu_rd,
    input  logic [7:0]  ppu_rdata,
    output logic [7:0]  oam_dma_addr,
    output logic [7:0]  oam_dma_data,
    output logic        oam_dma_wr
);

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_e;

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  pwdata_q, pwdata_d;
    logic        pwr_q, pwr_d;
    logic        prd_q, prd_d;

    logic [7:0]  ram_q [0:2047];

    logic        sample;
    logic        is_ram, is_ppu, is_prg, is_dma;
    logic        ram_we;
    logic [7:0]  cpu_read_val;
    logic [7:0]  dma_src;

    assign sample = (state_q == DMA_IDLE);
    assign is_ram = (cpu_addr[15:13] == 3'b000);
    assign is_ppu = (cpu_addr[15:13] == 3'b001);
    assign is_prg = cpu_addr[15];
    assign is_dma = (cpu_addr == 16'h4014);

    assign ram_we = rst && sample && cpu_write_en && is_ram;

    // Reads from $4014 and every other unmapped location fall through to $00.
    always_comb begin
        cpu_read_val = 8'h00;
        if (is_ram) begin
            cpu_read_val = ram_q[cpu_addr[10:0]];
        end else if (is_ppu) begin
            cpu_read_val = ppu_rdata;
        end else if (is_prg) begin
            cpu_read_val = prg_data;
        end
    end

    always_comb begin
        dma_src = 8'h00;
        if (page_q[7:5] == 3'b000) begin
            dma_src = ram_q[{page_q[2:0], n_q}];
        end else if (page_q[7]) begin
            dma_src = prg_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        n_d      = n_q;
        byte_d   = byte_q;
        rdata_d  = rdata_q;
        sel_d    = sel_q;
        pwdata_d = pwdata_q;
        pwr_d    = 1'b0;
        prd_d    = 1'b0;

        if (sample) begin
            if (cpu_write_en) begin
                rdata_d = cpu_wdata;
                if (is_ppu) begin
                    pwr_d    = 1'b1;
                    sel_d    = cpu_addr[2:0];
                    pwdata_d = cpu_wdata;
                end
                if (is_dma) begin
                    state_d = DMA_ALIGN;
                    page_d  = cpu_wdata;
                    n_d     = 8'h00;
                end
            end else begin
                rdata_d = cpu_read_val;
                if (is_ppu) begin
                    prd_d = 1'b1;
                    sel_d = cpu_addr[2:0];
                end
            end
        end

        case (state_q)
            DMA_ALIGN: state_d = DMA_READ;
            DMA_READ: begin
                byte_d  = dma_src;
                state_d = DMA_WRITE;
            end
            DMA_WRITE: begin
                // The last byte returns to idle with n parked at $FF rather than wrapping.
                if (n_q == 8'hFF) begin
                    state_d = DMA_IDLE;
                end else begin
                    n_d     = n_q + 8'd1;
                    state_d = DMA_READ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DMA_IDLE;
            page_q   <= 8'h00;
            n_q      <= 8'h00;
            byte_q   <= 8'h00;
            rdata_q  <= 8'h00;
            sel_q    <= 3'd0;
            pwdata_q <= 8'h00;
            pwr_q    <= 1'b0;
            prd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            n_q      <= n_d;
            byte_q   <= byte_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
            pwdata_q <= pwdata_d;
            pwr_q    <= pwr_d;
            prd_q    <= prd_d;
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[cpu_addr[10:0]] <= cpu_wdata;
        end
    end

    assign cpu_rdata    = rdata_q;
    assign cpu_stall    = (state_q != DMA_IDLE);
    assign prg_addr     = (state_q == DMA_READ) ? {page_q[6:0], n_q} : cpu_addr[14:0];
    assign ppu_reg_sel  = sel_q;
    assign ppu_wdata    = pwdata_q;
    assign ppu_wr       = pwr_q;
    assign ppu_rd       = prd_q;
    assign oam_dma_wr   = (state_q == DMA_WRITE);
    assign oam_dma_addr = n_q;
    assign oam_dma_data = byte_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: stimulus queues expected responses, a negedge monitor consumes them.
// PRG ROM and PPU register file are modelled as simple combinational functions of their addresses.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write_en;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic [2:0]  ppu_reg_sel;
    logic [7:0]  ppu_wdata;
    logic        ppu_wr;
    logic        ppu_rd;
    logic [7:0]  ppu_rdata;
    logic [7:0]  oam_dma_addr;
    logic [7:0]  oam_dma_data;
    logic        oam_dma_wr;

    cpu_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_write_en (cpu_write_en),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .prg_addr     (prg_addr),
        .prg_data     (prg_data),
        .ppu_reg_sel  (ppu_reg_sel),
        .ppu_wdata    (ppu_wdata),
        .ppu_wr       (ppu_wr),
        .ppu_rd       (ppu_rd),
        .ppu_rdata    (ppu_rdata),
        .oam_dma_addr (oam_dma_addr),
        .oam_dma_data (oam_dma_data),
        .oam_dma_wr   (oam_dma_wr)
    );

    assign prg_data  = prg_addr[7:0] ^ 8'hC8;
    assign ppu_rdata = 8'hC1 + {5'b00000, cpu_addr[2:0]};

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } rexp_t;

    rexp_t       rq[$];
    logic [15:0] pwq[$];
    logic [15:0] prq[$];
    logic [15:0] oq[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int stall_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s unexpected strobe at cycle %0d", name, cyc);
    endtask

    // Monitor: compares whatever the DUT presents against the head of each queue.
    always @(negedge clk) begin
        if (rst) begin
            if (cpu_stall) stall_cnt++;
            while (rq.size() > 0 && rq[0].cyc <= cyc) begin
                rexp_t e;
                e = rq.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL rdata missed cycle %0d required=%0h", e.cyc, e.val);
                end else begin
                    check("cpu_rdata", 16'(cpu_rdata), 16'(e.val));
                end
            end
            if (ppu_wr) begin
                if (pwq.size() == 0) unexpected("ppu_wr");
                else check("ppu_wr_sel_data", 16'({ppu_reg_sel, ppu_wdata}), pwq.pop_front());
            end
            if (ppu_rd) begin
                if (prq.size() == 0) unexpected("ppu_rd");
                else check("ppu_rd_sel", 16'(ppu_reg_sel), prq.pop_front());
            end
            if (oam_dma_wr) begin
                if (oq.size() == 0) unexpected("oam_dma_wr");
                else check("oam_addr_data", {oam_dma_addr, oam_dma_data}, oq.pop_front());
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
        @(posedge clk);
        #1;
        cpu_addr     = a;
        cpu_wdata    = d;
        cpu_write_en = we;
    endtask

    task automatic op(input logic [15:0] a, input logic [7:0] d, input logic we, input logic [7:0] exp);
        rexp_t e;
        drive(a, d, we);
        e.cyc = cyc + 1;
        e.val = exp;
        rq.push_back(e);
    endtask

    task automatic idle();
        drive(16'h5000, 8'h00, 1'b0);
    endtask

    task automatic wait_dma(input string name);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            if (cpu_stall) seen = 1'b1;
            else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s dma end timeout seen=%0d", name, seen);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"},    16'(cpu_rdata),    16'h0000);
        check({tag, "_stall"},    16'(cpu_stall),    16'h0000);
        check({tag, "_ppu_wr"},   16'(ppu_wr),       16'h0000);
        check({tag, "_ppu_rd"},   16'(ppu_rd),       16'h0000);
        check({tag, "_ppu_sel"},  16'(ppu_reg_sel),  16'h0000);
        check({tag, "_ppu_wd"},   16'(ppu_wdata),    16'h0000);
        check({tag, "_oam_wr"},   16'(oam_dma_wr),   16'h0000);
        check({tag, "_oam_addr"}, 16'(oam_dma_addr), 16'h0000);
        check({tag, "_oam_data"}, 16'(oam_dma_data), 16'h0000);
    endtask

    initial begin
        bit drained;
        rst          = 1'b1;
        cpu_addr     = 16'h5000;
        cpu_wdata    = 8'h00;
        cpu_write_en = 1'b0;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("init");
        @(posedge clk);
        #3 rst = 1'b1;

        // RAM write-first and mirrored read.
        op(16'h0105, 8'h5A, 1'b1, 8'h5A);
        op(16'h5000, 8'h00, 1'b0, 8'h00);
        op(16'h1905, 8'h00, 1'b0, 8'h5A);

        // PPU write strobe and read side-effect strobe.
        pwq.push_back(16'({3'd0, 8'h80}));
        op(16'h2008, 8'h80, 1'b1, 8'h80);
        prq.push_back(16'd2);
        op(16'h3FFA, 8'h00, 1'b0, 8'hC3);

        // PRG ROM read, ignored PRG write.
        op(16'h0000, 8'h11, 1'b1, 8'h11);
        op(16'hFFFC, 8'h00, 1'b0, 8'h34);
        #1 check("prg_addr", 16'(prg_addr), 16'h7FFC);
        op(16'h8000, 8'hEE, 1'b1, 8'hEE);
        idle();
        #1;
        check("prg_wr_ppu_sel", 16'(ppu_reg_sel), 16'h0002);
        check("prg_wr_ppu_wd",  16'(ppu_wdata),   16'h0080);
        op(16'h0000, 8'h00, 1'b0, 8'h11);

        // Fill page 2 and transfer it; bus activity during the stall must be ignored.
        for (int i = 0; i < 256; i++) begin
            op(16'h0200 + 16'(i), 8'(i) ^ 8'hA5, 1'b1, 8'(i) ^ 8'hA5);
        end
        for (int i = 0; i < 256; i++) oq.push_back({8'(i), 8'(i) ^ 8'hA5});
        idle();
        stall_cnt = 0;
        op(16'h4014, 8'h02, 1'b1, 8'h02);
        drive(16'h0200, 8'h77, 1'b1);
        drive(16'h2001, 8'h99, 1'b1);
        idle();
        #1;
        check("dma1_stall_mid", 16'(cpu_stall), 16'h0001);
        check("dma1_rdata_hold", 16'(cpu_rdata), 16'h0002);
        wait_dma("dma1");
        check("dma1_stall_cycles", 16'(stall_cnt), 16'd513);
        op(16'h0200, 8'h00, 1'b0, 8'hA5);
        op(16'h02FF, 8'h00, 1'b0, 8'h5A);

        // Transfer from PRG page $80.
        for (int i = 0; i < 256; i++) oq.push_back({8'(i), 8'(i) ^ 8'hC8});
        idle();
        stall_cnt = 0;
        op(16'h4014, 8'h80, 1'b1, 8'h80);
        idle();
        wait_dma("dma2");
        check("dma2_stall_cycles", 16'(stall_cnt), 16'd513);

        // Unmapped accesses, including a read of $4014.
        op(16'h1905, 8'h00, 1'b0, 8'h5A);
        op(16'h4015, 8'h00, 1'b1, 8'h00);
        op(16'h0105, 8'h00, 1'b0, 8'h5A);
        op(16'h4014, 8'h00, 1'b0, 8'h00);
        op(16'h0105, 8'h00, 1'b0, 8'h5A);
        op(16'h5000, 8'h00, 1'b0, 8'h00);
        idle();
        #1 check("unmapped_stall", 16'(cpu_stall), 16'h0000);

        // Reset in the middle of a transfer, right after byte 99 has been written.
        for (int i = 0; i < 100; i++) oq.push_back({8'(i), 8'(i) ^ 8'hA5});
        op(16'h4014, 8'h02, 1'b1, 8'h02);
        idle();
        drained = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #2;
            if (oq.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("abort_reached_byte100", 16'(drained), 16'h0001);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        #1 check("abort_held_stall", 16'(cpu_stall), 16'h0000);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (600) @(posedge clk);
        #1 check("post_abort_stall", 16'(cpu_stall), 16'h0000);
        op(16'h0200, 8'h00, 1'b0, 8'hA5);
        idle();
        repeat (3) @(posedge clk);

        check("rd_queue_left",  16'(rq.size()),  16'h0000);
        check("pwr_queue_left", 16'(pwq.size()), 16'h0000);
        check("prd_queue_left", 16'(prq.size()), 16'h0000);
        check("oam_queue_left", 16'(oq.size()),  16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
